alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (4-bit alu_main control code) between two requesters, e.g. port 0 = execute path, port 1 = address/branch-compare helper.
- Round-robin arbitration with valid/ready handshake on each request port.
- Drives the shared ALU's control and operand inputs and captures its result into a one-entry response buffer per requester.
- Sits between the requesters and the ALU; the ALU itself is unchanged.

Parameters:
- XLEN, 32, operand/result width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  bit i = requester i presents an operation.
- req_ready  out  2  bit i = requester i accepted this cycle.
- req_ctrl  in  8  {ctrl1,ctrl0}, 4-bit ALU code per requester.
- req_a  in  2*XLEN  {a1,a0} operand A per requester.
- req_b  in  2*XLEN  {b1,b0} operand B per requester.
- alu_ctrl  out  4  to shared ALU control.
- alu_a  out  XLEN  to shared ALU operand A.
- alu_b  out  XLEN  to shared ALU operand B.
- alu_result  in  XLEN  from shared ALU, combinational.
- alu_zero  in  1  from shared ALU, result==0.
- rsp_valid  out  2  bit i = response buffer i full.
- rsp_ready  in  2  bit i = requester i consumes its response.
- rsp_data  out  2*XLEN  {d1,d0} captured result.
- rsp_zero  out  2  captured zero flag.
- rsp_err  out  2  captured illegal-code flag.

Behaviour:
- Legal codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0111 sltu, 1000 sll, 1111 srl, 1001 sra. All other codes are illegal.
- Eligibility: elig[i] = req_valid[i] & (~rsp_valid[i] | rsp_ready[i]). A full buffer that is draining this cycle counts as free.
- Grant (combinational): at most one per cycle.
  - If only one requester is eligible, it is granted.
  - If both are eligible, the requester selected by priority pointer rr is granted.
- req_ready = grant. A transfer on port i occurs when req_valid[i] & req_ready[i].
- Requesters hold valid and payload stable until ready. The arbiter does not depend on this for correctness.
- rr update at the clock edge: after a grant to i, rr <= ~i. With no grant, rr holds. Reset value is 0, so requester 0 wins the first tie.
- ALU drive: the granted requester's ctrl/a/b are muxed to alu_ctrl/alu_a/alu_b. With no grant, drive alu_ctrl=0000 and alu_a=alu_b=0.
- Capture: at the edge ending the grant cycle, for the granted i:
  - rsp_valid[i] <= 1.
  - Legal code: rsp_data[i] <= alu_result, rsp_zero[i] <= alu_zero, rsp_err[i] <= 0.
  - Illegal code: rsp_data[i] <= 0, rsp_zero[i] <= 1, rsp_err[i] <= 1. This result is never forwarded as valid data.
- Latency: accepted in cycle N, rsp_valid at N+1. Throughput is one operation per cycle across both ports; each port can sustain one per cycle when its rsp_ready is held high.
- Drain: when rsp_valid[i] & rsp_ready[i] and no new grant to i, rsp_valid[i] <= 0. Data fields hold their last value.
- Simultaneous drain and grant on the same port: the buffer is overwritten with the new result and rsp_valid stays 1 (no bubble).
- rsp_ready[i] while rsp_valid[i]=0 is ignored.
- Fairness: a continuously eligible requester is granted within 2 cycles.
- Reset (async, any time): rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0, rr=0. In-flight responses are discarded. Outputs that depend on inputs (req_ready, alu_*) follow the grant logic; with rsp_valid=0 after reset, grant depends only on req_valid.
- Width: no arithmetic in this block beyond muxing. Operands pass unmodified.

Decomposition:
- Shared package alu_pkg:
  - localparams for the ten 4-bit ALU codes.
  - a function is_legal_alu_code(code).
  - XLEN default.
- Sub-module rr_arb2: 2-input round-robin arbiter.
  - Inputs: elig[1:0], rr.
  - Outputs: grant[1:0] (one-hot or zero), next_rr.
  - Purely combinational, instanced once. The rr register lives in the top module.

Test Plan:
- Reset, then only req0 valid with ctrl=0000, a=5, b=7 -> req_ready=01 that cycle; next cycle rsp_valid=01, d0=12, rsp_zero0=0, rsp_err0=0.
- Both valid for 4 cycles, rsp_ready=11, req0 sub 9-9, req1 xor 0xF0^0x0F -> grants 01,10,01,10; d0=0 with zero=1; d1=0xFF.
- req1 ctrl=0110 (illegal) -> rsp_valid1=1, rsp_err1=1, d1=0, rsp_zero1=1.
- rsp_ready0=0 with rsp_valid0=1 and req0 valid again -> req_ready0=0, req1 still granted. Raise rsp_ready0 -> req0 granted that same cycle, rsp_valid0 stays 1 with the new data.
- Assert rst mid-stream with both buffers full -> rsp_valid=00 immediately, rr=0; first tie after release grants req0.
- req0 sra a=0x80000000, b=4 via a behavioural ALU model -> d0=0xF8000000; req1 sll a=1, b=31 -> d1=0x80000000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control-code definitions and the legality check used by the
// arbiter when capturing results.
package alu_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1111;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  function automatic logic is_legal_alu_code(input logic [3:0] code);
    logic legal;
    case (code)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA: legal = 1'b1;
      default:                                      legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant logic; the priority pointer register is held
// by the caller, this block only computes the grant and the next pointer.
module rr_arb2 (
  input  logic [1:0] elig,
  input  logic       rr,
  output logic [1:0] grant,
  output logic       next_rr
);

  always_comb begin
    grant = elig;
    if (&elig) begin
      grant = rr ? 2'b10 : 2'b01;
    end
    next_rr = rr;
    if (grant[0]) begin
      next_rr = 1'b1;
    end else if (grant[1]) begin
      next_rr = 1'b0;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin
// arbitration and a one-entry response buffer per requester.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [7:0]          req_ctrl,
  input  logic [2*XLEN-1:0]   req_a,
  input  logic [2*XLEN-1:0]   req_b,
  output logic [3:0]          alu_ctrl,
  output logic [XLEN-1:0]     alu_a,
  output logic [XLEN-1:0]     alu_b,
  input  logic [XLEN-1:0]     alu_result,
  input  logic                alu_zero,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [2*XLEN-1:0]   rsp_data,
  output logic [1:0]          rsp_zero,
  output logic [1:0]          rsp_err
);

  logic                  rr_q;
  logic                  rr_d;
  logic [1:0]            elig;
  logic [1:0]            grant;
  logic                  ctrl_legal;
  logic [1:0]            rsp_valid_q;
  logic [1:0][XLEN-1:0]  rsp_data_q;
  logic [1:0]            rsp_zero_q;
  logic [1:0]            rsp_err_q;

  // A full buffer that is being drained this cycle can accept a new result.
  assign elig = req_valid & (~rsp_valid_q | rsp_ready);

  rr_arb2 u_arb (
    .elig    (elig),
    .rr      (rr_q),
    .grant   (grant),
    .next_rr (rr_d)
  );

  assign req_ready = grant;

  always_comb begin
    alu_ctrl = '0;
    alu_a    = '0;
    alu_b    = '0;
    if (grant[0]) begin
      alu_ctrl = req_ctrl[3:0];
      alu_a    = req_a[XLEN-1:0];
      alu_b    = req_b[XLEN-1:0];
    end else if (grant[1]) begin
      alu_ctrl = req_ctrl[7:4];
      alu_a    = req_a[2*XLEN-1:XLEN];
      alu_b    = req_b[2*XLEN-1:XLEN];
    end
  end

  assign ctrl_legal = is_legal_alu_code(alu_ctrl);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= '0;
      rsp_err_q   <= '0;
    end else begin
      rr_q <= rr_d;
      for (int unsigned i = 0; i < 2; i++) begin
        if (grant[i[0]]) begin
          // A grant overrides a same-cycle drain, so the buffer stays full.
          rsp_valid_q[i[0]] <= 1'b1;
          if (ctrl_legal) begin
            rsp_data_q[i[0]] <= alu_result;
            rsp_zero_q[i[0]] <= alu_zero;
            rsp_err_q[i[0]]  <= 1'b0;
          end else begin
            rsp_data_q[i[0]] <= '0;
            rsp_zero_q[i[0]] <= 1'b1;
            rsp_err_q[i[0]]  <= 1'b1;
          end
        end else if (rsp_ready[i[0]]) begin
          rsp_valid_q[i[0]] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized bench for alu_share_arbiter with an external ALU
// model and a transaction-level reference of arbitration and buffering.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_ctrl;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_zero;
  logic [1:0]  rsp_err;

  int checks = 0;
  int errors = 0;

  // Reference state: buffer contents per port and the port that wins a tie.
  bit          m_v[2];
  logic [31:0] m_d[2];
  bit          m_z[2];
  bit          m_e[2];
  int          m_pri;

  alu_share_arbiter #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ctrl   (req_ctrl),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit ref_legal(input logic [3:0] c);
    return c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd15};
  endfunction

  // Illegal codes yield junk so any forwarding of it is visible.
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:    return (a < b) ? 32'd1 : 32'd0;
      4'd8:    return a << b[4:0];
      4'd15:   return a >> b[4:0];
      4'd9:    return 32'($signed(a) >>> b[4:0]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_ctrl, alu_a, alu_b);
  assign alu_zero   = (alu_result == 32'd0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 1'b0; m_d[i] = '0; m_z[i] = 1'b0; m_e[i] = 1'b0;
    end
    m_pri = 0;
  endtask

  task automatic check_rsp(input string tag);
    check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'({m_v[1], m_v[0]}));
    check({tag, ".rsp_data"},  rsp_data,       {m_d[1], m_d[0]});
    check({tag, ".rsp_zero"},  64'(rsp_zero),  64'({m_z[1], m_z[0]}));
    check({tag, ".rsp_err"},   64'(rsp_err),   64'({m_e[1], m_e[0]}));
  endtask

  // One clock cycle: starts and ends just after a rising edge.
  task automatic step(input string tag, input logic [1:0] v,
                      input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic [1:0] rdy);
    logic [3:0]  c[2];
    logic [31:0] a[2];
    logic [31:0] b[2];
    bit          e[2];
    int          g;
    logic [3:0]  xc;
    logic [31:0] xa, xb, res;
    c[0] = c0; c[1] = c1; a[0] = a0; a[1] = a1; b[0] = b0; b[1] = b1;
    req_valid = v;
    req_ctrl  = {c1, c0};
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    rsp_ready = rdy;
    #2;
    for (int i = 0; i < 2; i++) e[i] = v[i] && (!m_v[i] || rdy[i]);
    if (e[0] && e[1]) g = m_pri;
    else if (e[0])    g = 0;
    else if (e[1])    g = 1;
    else              g = -1;
    xc = (g < 0) ? 4'd0  : c[g];
    xa = (g < 0) ? 32'd0 : a[g];
    xb = (g < 0) ? 32'd0 : b[g];
    check({tag, ".req_ready"}, 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    check({tag, ".alu_ctrl"},  64'(alu_ctrl),  64'(xc));
    check({tag, ".alu_a"},     64'(alu_a),     64'(xa));
    check({tag, ".alu_b"},     64'(alu_b),     64'(xb));
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (g == i) begin
        m_v[i] = 1'b1;
        if (ref_legal(c[i])) begin
          res = ref_alu(c[i], a[i], b[i]);
          m_d[i] = res; m_z[i] = (res == 32'd0); m_e[i] = 1'b0;
        end else begin
          m_d[i] = '0; m_z[i] = 1'b1; m_e[i] = 1'b1;
        end
      end else if (m_v[i] && rdy[i]) begin
        m_v[i] = 1'b0;
      end
    end
    if (g >= 0) m_pri = 1 - g;
    #1;
    check_rsp(tag);
  endtask

  initial begin
    logic [31:0] ra0, rb0, ra1, rb1;
    rst = 1'b1; req_valid = '0; req_ctrl = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    model_reset();
    #1;
    check_rsp("reset");
    check("reset.req_ready", 64'(req_ready), 64'd0);
    check("reset.alu_ctrl",  64'(alu_ctrl),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    step("add0", 2'b01, 4'd0, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0, 2'b00);
    check("add0.d0", 64'(rsp_data[31:0]), 64'd12);

    step("r1only", 2'b10, 4'd0, 32'd1, 32'd1, 4'd0, 32'd2, 32'd3, 2'b11);
    for (int k = 0; k < 4; k++)
      step("tie", 2'b11, 4'd1, 32'd9, 32'd9, 4'd4, 32'hF0, 32'h0F, 2'b11);
    check("tie.d0",    64'(rsp_data[31:0]),  64'd0);
    check("tie.zero0", 64'(rsp_zero[0]),     64'd1);
    check("tie.d1",    64'(rsp_data[63:32]), 64'hFF);

    step("illegal1", 2'b10, 4'd0, 32'd0, 32'd0, 4'b0110, 32'd3, 32'd4, 2'b11);
    check("illegal1.err1", 64'(rsp_err[1]), 64'd1);
    check("illegal1.d1",   64'(rsp_data[63:32]), 64'd0);

    step("fill0", 2'b01, 4'd0, 32'd10, 32'd20, 4'd0, 32'd0, 32'd0, 2'b11);
    step("bp0", 2'b11, 4'd0, 32'd100, 32'd1, 4'd3, 32'h10, 32'h01, 2'b10);
    step("drain_grant0", 2'b11, 4'd0, 32'd100, 32'd1, 4'd3, 32'h10, 32'h01, 2'b11);
    check("drain_grant0.d0", 64'(rsp_data[31:0]), 64'd101);

    step("sra0", 2'b01, 4'd9, 32'h8000_0000, 32'd4, 4'd0, 32'd0, 32'd0, 2'b01);
    check("sra0.d0", 64'(rsp_data[31:0]), 64'hF800_0000);
    step("sll1", 2'b10, 4'd0, 32'd0, 32'd0, 4'd8, 32'd1, 32'd31, 2'b10);
    check("sll1.d1", 64'(rsp_data[63:32]), 64'h8000_0000);
    step("pre_rst", 2'b01, 4'd2, 32'hFF, 32'h0F, 4'd0, 32'd0, 32'd0, 2'b01);

    req_valid = '0;
    rst = 1'b1;
    #1;
    model_reset();
    check_rsp("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    step("post_rst_tie", 2'b11, 4'd0, 32'd1, 32'd2, 4'd0, 32'd3, 32'd4, 2'b00);
    check("post_rst_tie.valid", 64'(rsp_valid), 64'b01);

    for (int n = 0; n < 300; n++) begin
      ra0 = $urandom; ra1 = $urandom;
      rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
      rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
      step("rand", 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), ra0, rb0,
           4'($urandom_range(0, 15)), ra1, rb1, 2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
